// File: rtl/LLC_defs.sv
// rtl/LLC_defs.sv - opcode constants, request layout and FSM states for the LLC request scheduler
package LLC_defs;

  localparam logic [3:0] OP_RD_DATA   = 4'd0;
  localparam logic [3:0] OP_WR_DATA   = 4'd1;
  localparam logic [3:0] OP_RD_INSTR  = 4'd2;
  localparam logic [3:0] OP_SNP_RD    = 4'd3;
  localparam logic [3:0] OP_SNP_WR    = 4'd4;
  localparam logic [3:0] OP_SNP_RWIM  = 4'd5;
  localparam logic [3:0] OP_SNP_INVAL = 4'd6;
  localparam logic [3:0] OP_CLEAR     = 4'd8;
  localparam logic [3:0] OP_PRINT     = 4'd9;
  localparam logic [3:0] OP_NOP       = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUBBLE
  } state_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] addr;
  } req_t;

  function automatic logic cpu_op_legal(input logic [3:0] op);
    case (op)
      OP_RD_DATA, OP_WR_DATA, OP_RD_INSTR, OP_CLEAR, OP_PRINT: cpu_op_legal = 1'b1;
      default: cpu_op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic snp_op_legal(input logic [3:0] op);
    case (op)
      OP_SNP_RD, OP_SNP_WR, OP_SNP_RWIM, OP_SNP_INVAL: snp_op_legal = 1'b1;
      default: snp_op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_maint(input logic [3:0] op);
    is_maint = (op == OP_CLEAR) || (op == OP_PRINT);
  endfunction

endpackage

// File: rtl/llc_req_scheduler_if.sv
// rtl/llc_req_scheduler_if.sv - request, snoop and issue signals of the LLC request scheduler
interface llc_req_scheduler_if;

  logic        cpu_valid;
  logic [3:0]  cpu_op;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic        snp_valid;
  logic [3:0]  snp_op;
  logic [31:0] snp_addr;
  logic        snp_ready;
  logic        llc_hold;
  logic        iss_valid;
  logic [3:0]  iss_op;
  logic [31:0] iss_addr;
  logic        op_err;

  modport master (
    output cpu_valid, cpu_op, cpu_addr, snp_valid, snp_op, snp_addr, llc_hold,
    input  cpu_ready, snp_ready, iss_valid, iss_op, iss_addr, op_err
  );

  modport slave (
    input  cpu_valid, cpu_op, cpu_addr, snp_valid, snp_op, snp_addr, llc_hold,
    output cpu_ready, snp_ready, iss_valid, iss_op, iss_addr, op_err
  );

endinterface

// File: rtl/llc_req_fifo.sv
// rtl/llc_req_fifo.sv - small synchronous FIFO holding pending requests for one requester
module llc_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/llc_req_scheduler.sv
// rtl/llc_req_scheduler.sv - arbitrates CPU and snoop request queues into a single registered LLC issue port
module llc_req_scheduler
  import LLC_defs::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  llc_req_scheduler_if.slave   bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          iss_valid_q, iss_valid_d;
  logic [3:0]    iss_op_q, iss_op_d;
  logic [31:0]   iss_addr_q, iss_addr_d;
  logic          op_err_q, op_err_d;

  logic cpu_ready, snp_ready, cpu_fire, snp_fire, cpu_push, snp_push;
  logic cpu_full, cpu_empty, snp_full, snp_empty, cpu_pop, snp_pop;
  logic cpu_maint, cpu_ok, cpu_win;
  req_t cpu_head, snp_head;

  assign cpu_ready = rst_n && !cpu_full;
  assign snp_ready = rst_n && !snp_full;
  assign cpu_fire  = bus.cpu_valid && cpu_ready;
  assign snp_fire  = bus.snp_valid && snp_ready;
  assign cpu_push  = cpu_fire && cpu_op_legal(bus.cpu_op);
  assign snp_push  = snp_fire && snp_op_legal(bus.snp_op);

  llc_req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(req_t))) u_cpu_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(cpu_push), .push_data({bus.cpu_op, bus.cpu_addr}),
    .pop(cpu_pop), .full(cpu_full), .empty(cpu_empty), .head(cpu_head)
  );

  llc_req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(req_t))) u_snp_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(snp_push), .push_data({bus.snp_op, bus.snp_addr}),
    .pop(snp_pop), .full(snp_full), .empty(snp_empty), .head(snp_head)
  );

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    iss_valid_d = 1'b0;
    iss_op_d    = OP_NOP;
    iss_addr_d  = '0;
    cpu_pop     = 1'b0;
    snp_pop     = 1'b0;
    // A maintenance op at the CPU head waits for the snoop queue to drain.
    cpu_maint   = is_maint(cpu_head.op);
    cpu_ok      = !cpu_empty && (!cpu_maint || snp_empty);
    cpu_win     = cpu_ok && (snp_empty || starve_q == SW'(STARVE_MAX));
    op_err_d    = (cpu_fire && !cpu_op_legal(bus.cpu_op)) ||
                  (snp_fire && !snp_op_legal(bus.snp_op));

    if (state_q == ISSUE && bus.llc_hold) begin
      state_d = BUBBLE;
    end else if (cpu_win) begin
      state_d     = ISSUE;
      iss_valid_d = 1'b1;
      iss_op_d    = cpu_head.op;
      iss_addr_d  = cpu_head.addr;
      cpu_pop     = 1'b1;
    end else if (!snp_empty) begin
      state_d     = ISSUE;
      iss_valid_d = 1'b1;
      iss_op_d    = snp_head.op;
      iss_addr_d  = snp_head.addr;
      snp_pop     = 1'b1;
    end else begin
      state_d = IDLE;
    end

    if (cpu_empty || cpu_pop) begin
      starve_d = '0;
    end else if (snp_pop && !cpu_maint && starve_q != SW'(STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= OP_NOP;
      iss_addr_q  <= '0;
      op_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      iss_valid_q <= iss_valid_d;
      iss_op_q    <= iss_op_d;
      iss_addr_q  <= iss_addr_d;
      op_err_q    <= op_err_d;
    end
  end

  assign bus.cpu_ready = cpu_ready;
  assign bus.snp_ready = snp_ready;
  assign bus.iss_valid = iss_valid_q;
  assign bus.iss_op    = iss_op_q;
  assign bus.iss_addr  = iss_addr_q;
  assign bus.op_err    = op_err_q;

endmodule

// File: tb/tb_llc_req_scheduler.sv
// tb/tb_llc_req_scheduler.sv - self-checking bench for llc_req_scheduler against a queue-level model
module tb_llc_req_scheduler;

  localparam int DEPTH  = 4;
  localparam int STARVE = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  llc_req_scheduler_if bus ();

  llc_req_scheduler #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int   errs = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;

  logic [35:0] mcpu[$];
  logic [35:0] msnp[$];
  logic [35:0] dlog[$];
  logic [35:0] mlog[$];
  int          starve = 0;
  logic        m_valid = 1'b0;
  logic [3:0]  m_op = 4'd15;
  logic [31:0] m_addr = '0;
  logic        m_err = 1'b0;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_issue(input string name, input logic [3:0] op, input logic [31:0] addr);
    if (dlog.size() == 0) begin
      checks++; errs++;
      $display("FAIL %s actual=no_issue required=%0h", name, {op, addr});
    end else chk(name, dlog.pop_front(), {op, addr});
    if (mlog.size() == 0) begin
      checks++; errs++;
      $display("FAIL model_%s actual=no_issue required=%0h", name, {op, addr});
    end else chk({"model_", name}, mlog.pop_front(), {op, addr});
  endtask

  task automatic expect_no_more(input string name);
    chk(name, 36'(dlog.size()), 36'd0);
    chk({"model_", name}, 36'(mlog.size()), 36'd0);
    dlog.delete();
    mlog.delete();
  endtask

  // Queue-level reference: handshake, arbitration and hold rules applied per clock edge.
  always @(posedge clk) begin : model
    logic [35:0] e;
    bit had_cpu, cmaint, cturn, cfire, sfire, snp_avail;
    if (!rst_n) begin
      mcpu.delete();
      msnp.delete();
      starve  = 0;
      m_valid = 1'b0;
      m_op    = 4'd15;
      m_addr  = '0;
      m_err   = 1'b0;
    end else begin
      cfire     = bus.cpu_valid && (mcpu.size() < DEPTH);
      sfire     = bus.snp_valid && (msnp.size() < DEPTH);
      had_cpu   = (mcpu.size() != 0);
      snp_avail = (msnp.size() != 0);
      cmaint    = had_cpu && (mcpu[0][35:32] inside {4'd8, 4'd9});
      if (m_valid && bus.llc_hold) begin
        m_valid = 1'b0; m_op = 4'd15; m_addr = '0;
      end else begin
        cturn = had_cpu && (!cmaint || !snp_avail) && (!snp_avail || starve == STARVE);
        if (cturn) begin
          e = mcpu.pop_front();
          m_valid = 1'b1; m_op = e[35:32]; m_addr = e[31:0];
          starve = 0;
        end else if (snp_avail) begin
          e = msnp.pop_front();
          m_valid = 1'b1; m_op = e[35:32]; m_addr = e[31:0];
          if (had_cpu && !cmaint && starve < STARVE) starve++;
        end else begin
          m_valid = 1'b0; m_op = 4'd15; m_addr = '0;
        end
      end
      if (!had_cpu) starve = 0;
      m_err = (cfire && !(bus.cpu_op inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd9})) ||
              (sfire && !(bus.snp_op inside {4'd3, 4'd4, 4'd5, 4'd6}));
      if (cfire && (bus.cpu_op inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd9}))
        mcpu.push_back({bus.cpu_op, bus.cpu_addr});
      if (sfire && (bus.snp_op inside {4'd3, 4'd4, 4'd5, 4'd6}))
        msnp.push_back({bus.snp_op, bus.snp_addr});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("iss_valid", 36'(bus.iss_valid), 36'(m_valid));
      chk("iss_op",    36'(bus.iss_op),    36'(m_op));
      chk("iss_addr",  36'(bus.iss_addr),  36'(m_addr));
      chk("op_err",    36'(bus.op_err),    36'(m_err));
      chk("cpu_ready", 36'(bus.cpu_ready), 36'(rst_n && (mcpu.size() < DEPTH)));
      chk("snp_ready", 36'(bus.snp_ready), 36'(rst_n && (msnp.size() < DEPTH)));
      if (bus.iss_valid) dlog.push_back({bus.iss_op, bus.iss_addr});
      if (m_valid) mlog.push_back({m_op, m_addr});
    end
  end

  logic [3:0] snp_ops [6];

  initial begin
    snp_ops = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd3, 4'd4};
    rst_n = 1'b0;
    bus.cpu_valid = 1'b0; bus.cpu_op = '0; bus.cpu_addr = '0;
    bus.snp_valid = 1'b0; bus.snp_op = '0; bus.snp_addr = '0;
    bus.llc_hold  = 1'b0;

    // Reset values
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_cpu_ready", 36'(bus.cpu_ready), 36'd0);
    chk("rst_iss_op", 36'(bus.iss_op), 36'd15);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cpu_ready", 36'(bus.cpu_ready), 36'd1);
    chk("post_rst_iss_valid", 36'(bus.iss_valid), 36'd0);

    // Single CPU read, one-cycle latency
    bus.cpu_valid = 1'b1; bus.cpu_op = 4'd0; bus.cpu_addr = 32'h0000_1234;
    tick();
    bus.cpu_valid = 1'b0;
    @(negedge clk);
    chk("single_lat0_valid", 36'(bus.iss_valid), 36'd0);
    tick();
    @(negedge clk);
    chk("single_valid", 36'(bus.iss_valid), 36'd1);
    chk("single_op_addr", {bus.iss_op, bus.iss_addr}, {4'd0, 32'h0000_1234});
    tick();
    @(negedge clk);
    chk("single_then_idle", 36'(bus.iss_valid), 36'd0);
    tick();
    expect_issue("single_log", 4'd0, 32'h0000_1234);
    expect_no_more("single_end");

    // Simultaneous CPU and snoop: snoop first
    bus.cpu_valid = 1'b1; bus.cpu_op = 4'd1; bus.cpu_addr = 32'hA0;
    bus.snp_valid = 1'b1; bus.snp_op = 4'd3; bus.snp_addr = 32'hB0;
    tick();
    bus.cpu_valid = 1'b0; bus.snp_valid = 1'b0;
    repeat (4) tick();
    expect_issue("pair_first", 4'd3, 32'hB0);
    expect_issue("pair_second", 4'd1, 32'hA0);
    expect_no_more("pair_end");

    // Snoop stream starves CPU for exactly STARVE_MAX grants
    for (int i = 0; i < 6; i++) begin
      bus.snp_valid = 1'b1; bus.snp_op = snp_ops[i]; bus.snp_addr = 32'h100 + 32'(i);
      bus.cpu_valid = (i == 0); bus.cpu_op = 4'd2; bus.cpu_addr = 32'h200;
      tick();
    end
    bus.snp_valid = 1'b0; bus.cpu_valid = 1'b0;
    repeat (5) tick();
    expect_issue("starve_s0", 4'd3, 32'h100);
    expect_issue("starve_s1", 4'd4, 32'h101);
    expect_issue("starve_s2", 4'd5, 32'h102);
    expect_issue("starve_cpu", 4'd2, 32'h200);
    expect_issue("starve_s3", 4'd6, 32'h103);
    expect_issue("starve_s4", 4'd3, 32'h104);
    expect_issue("starve_s5", 4'd4, 32'h105);
    expect_no_more("starve_end");

    // llc_hold inserts a one-cycle bubble, ignored while in the bubble
    bus.cpu_valid = 1'b1; bus.cpu_op = 4'd0; bus.cpu_addr = 32'h300;
    tick();
    bus.cpu_op = 4'd1; bus.cpu_addr = 32'h304;
    tick();
    bus.cpu_valid = 1'b0; bus.llc_hold = 1'b1;
    @(negedge clk);
    chk("hold_first", {bus.iss_op, bus.iss_addr}, {4'd0, 32'h300});
    tick();
    @(negedge clk);
    chk("hold_bubble_valid", 36'(bus.iss_valid), 36'd0);
    chk("hold_bubble_op", 36'(bus.iss_op), 36'd15);
    tick();
    @(negedge clk);
    chk("hold_second", {bus.iss_op, bus.iss_addr}, {4'd1, 32'h304});
    tick();
    bus.llc_hold = 1'b0;
    repeat (2) tick();
    expect_issue("hold_log0", 4'd0, 32'h300);
    expect_issue("hold_log1", 4'd1, 32'h304);
    expect_no_more("hold_end");

    // Illegal opcodes: dropped, single op_err pulse
    bus.cpu_valid = 1'b1; bus.cpu_op = 4'd7; bus.cpu_addr = 32'h600;
    tick();
    bus.cpu_valid = 1'b0;
    @(negedge clk);
    chk("illegal_err_pulse", 36'(bus.op_err), 36'd1);
    tick();
    @(negedge clk);
    chk("illegal_err_clear", 36'(bus.op_err), 36'd0);
    bus.cpu_valid = 1'b1; bus.cpu_op = 4'd10; bus.snp_valid = 1'b1; bus.snp_op = 4'd2;
    tick();
    bus.cpu_valid = 1'b0; bus.snp_valid = 1'b0;
    @(negedge clk);
    chk("dual_illegal_err", 36'(bus.op_err), 36'd1);
    tick();
    @(negedge clk);
    chk("dual_illegal_clear", 36'(bus.op_err), 36'd0);
    tick();
    expect_no_more("illegal_no_issue");

    // Maintenance op waits for snoops to drain
    bus.snp_valid = 1'b1; bus.snp_op = 4'd3; bus.snp_addr = 32'h400;
    tick();
    bus.snp_op = 4'd4; bus.snp_addr = 32'h404;
    bus.cpu_valid = 1'b1; bus.cpu_op = 4'd9; bus.cpu_addr = 32'h500;
    tick();
    bus.snp_valid = 1'b0; bus.cpu_valid = 1'b0;
    repeat (4) tick();
    expect_issue("maint_s0", 4'd3, 32'h400);
    expect_issue("maint_s1", 4'd4, 32'h404);
    expect_issue("maint_cpu", 4'd9, 32'h500);
    expect_no_more("maint_end");

    // Fill CPU queue under sustained hold, then reset while in BUBBLE
    bus.llc_hold = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.cpu_valid = 1'b1; bus.cpu_op = 4'd0; bus.cpu_addr = 32'h700 + 32'(4 * i);
      tick();
    end
    bus.cpu_valid = 1'b0;
    @(negedge clk);
    chk("full_cpu_ready", 36'(bus.cpu_ready), 36'd0);
    #1 rst_n = 1'b0;
    #1 chk("in_rst_cpu_ready", 36'(bus.cpu_ready), 36'd0);
    tick();
    rst_n = 1'b1;
    bus.llc_hold = 1'b0;
    @(negedge clk);
    chk("rel_cpu_ready", 36'(bus.cpu_ready), 36'd1);
    chk("rel_iss_valid", 36'(bus.iss_valid), 36'd0);
    tick();
    @(negedge clk);
    chk("rel_no_issue", 36'(bus.iss_valid), 36'd0);
    repeat (3) tick();
    expect_issue("fill_a", 4'd0, 32'h700);
    expect_issue("fill_b", 4'd0, 32'h704);
    expect_issue("fill_c", 4'd0, 32'h708);
    expect_no_more("fill_flushed");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/llc_req_scheduler.md
LLC_REQ_SCHEDULER -- requirements
Module: llc_req_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, entries per requester queue (power of two, >=2).
REQ-002 Parameter STARVE_MAX, default 3, consecutive snoop grants allowed while CPU work is pending.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 cpu_valid  in  1  local L1 request present.
REQ-006 cpu_op  in  4  trace opcode: 0 rd data, 1 wr data, 2 rd instr, 8 clear, 9 print.
REQ-007 cpu_addr  in  32  request address.
REQ-008 cpu_ready  out  1  CPU queue can accept.
REQ-009 snp_valid  in  1  snooped bus request present.
REQ-010 snp_op  in  4  opcode: 3 snoop rd, 4 snoop wr, 5 snoop RWIM, 6 snoop inval.
REQ-011 snp_addr  in  32  snooped address.
REQ-012 snp_ready  out  1  snoop queue can accept.
REQ-013 llc_hold  in  1  LLC needs one extra cycle for the op issued this cycle.
REQ-014 iss_valid  out  1  op/addr presented to LLC this cycle.
REQ-015 iss_op  out  4  issued opcode; OP_NOP (15) when iss_valid=0.
REQ-016 iss_addr  out  32  issued address; 0 when iss_valid=0.
REQ-017 op_err  out  1  one-cycle pulse: illegal opcode dropped.

Function
REQ-018 Handshake: transfer when valid && ready at a rising edge; ready = queue not full, no same-cycle pop bypass.
REQ-019 Legal opcodes per port as REQ-006/REQ-010; an illegal opcode completes the handshake, is not enqueued, and pulses op_err in the following cycle; simultaneous illegal ops on both ports give one op_err pulse.
REQ-020 Each queue is FIFO order, pointers wrap modulo FIFO_DEPTH; push and pop in the same edge keep occupancy constant.
REQ-021 FSM states IDLE, ISSUE, BUBBLE; iss_* are registered.
REQ-022 IDLE/ISSUE: at each edge, if a grant exists go to ISSUE with the granted head; else IDLE.
REQ-023 ISSUE with llc_hold=1 -> BUBBLE (iss_valid=0 for exactly one cycle, no pop); BUBBLE -> IDLE/ISSUE per REQ-022.
REQ-024 llc_hold is ignored in IDLE and BUBBLE.
REQ-025 Arbitration: snoop head wins over CPU head, except when the starvation count equals STARVE_MAX and the CPU queue is non-empty, then CPU wins.
REQ-026 Starvation count increments on each snoop grant with CPU queue non-empty, clears on any CPU grant or when CPU queue is empty, saturates at STARVE_MAX.
REQ-027 Maintenance ops (8, 9) at CPU head are granted only when the snoop queue is empty; while blocked they do not block snoop grants and do not advance the starvation count.
REQ-028 The granted entry pops on the edge it is loaded into iss_*; minimum latency: accepted at edge E -> iss_valid at edge E+1.
REQ-029 Sustained throughput is one issue per cycle with llc_hold=0, one per two cycles with llc_hold=1.

Reset
REQ-030 rst_n=0 at an edge: both queues empty, FSM IDLE, starvation count 0, iss_valid=0, iss_op=OP_NOP, iss_addr=0, op_err=0, cpu_ready=snp_ready=0 during reset cycles and 1 in the first cycle after.
REQ-031 Reset mid-operation (including in BUBBLE) discards all queued and in-flight ops; no op is issued in the first cycle after reset.

Structure
REQ-032 Opcode constants, OP_NOP, legality ranges, and the FSM state enum live in LLC_defs.
REQ-033 One sub-module llc_req_fifo (parameterised depth/width, synchronous active-low reset), instantiated for the CPU and snoop queues.

Verification
REQ-034 Single CPU op 0 @0x0000_1234, hold=0 -> iss_valid one cycle later, iss_op=0, iss_addr=0x0000_1234, then IDLE.
REQ-035 CPU op 1 @0xA0 and snoop op 3 @0xB0 same edge -> snoop issued first, CPU next cycle.
REQ-036 Continuous snoop stream + one CPU op 2, STARVE_MAX=3 -> three snoop issues then the CPU op.
REQ-037 Issue with llc_hold=1 -> next cycle iss_valid=0, iss_op=15; following cycle next queued op issues.
REQ-038 CPU op 7 -> handshake completes, op_err pulses once, nothing issued; CPU op 9 with 2 snoops queued -> op 9 issued after both snoops.
REQ-039 Fill CPU queue to 4 with rst_n=1 -> cpu_ready=0; assert rst_n=0 for one edge -> queues empty, no issue in the cycle after release.
